// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state encoding
//   clog2w()    : index/counter width helper, never returns less than 1
package uart_fifo_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Width needed to hold values 0..n-1; a 1-bit floor keeps degenerate
    // parameter choices from producing zero-width vectors.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_fifo_wr_arbiter_rr_pick.sv
// Combinational circular priority search.
//   valid : request vector
//   ptr   : index with highest priority this round
//   idx   : first set index at or after ptr, wrapping past N-1 to 0
//   any   : at least one request is set
module rr_pick
    import uart_fifo_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = clog2w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the offsets from farthest to nearest so the nearest valid
    // index after ptr is the one left standing; no early exit needed.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (valid[j]) begin
                idx = IW'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters.
// A grant covers one packet (up to req_last) or MAX_BURST beats, whichever
// comes first; each grant is followed by one idle arbitration cycle.
//   wr_clk, wr_rst : clock, synchronous active-high reset
//   req_valid/req_data/req_last/req_ready : per-requester beat handshake
//   fifo_wr_data/fifo_wr_en : write port toward the FIFO
//   fifo_wr_vld    : FIFO can accept a beat (not full)
//   grant_id       : current (or most recent) owner
//   busy           : a burst is in progress
module uart_fifo_wr_arbiter
    import uart_fifo_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 8,
    parameter  int MAX_BURST = 16,
    localparam int ID_W      = clog2w(N_REQ)
) (
    input  logic                    wr_clk,
    input  logic                    wr_rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       fifo_wr_data,
    output logic                    fifo_wr_en,
    input  logic                    fifo_wr_vld,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy
);

    localparam int CNT_W = clog2w(MAX_BURST + 1);

    arb_state_e                     state;
    logic [ID_W-1:0]                rr_ptr;
    logic [CNT_W-1:0]               beat_cnt;
    logic [N_REQ-1:0][DATA_W-1:0]   req_data_a;
    logic [ID_W-1:0]                pick_idx;
    logic                           pick_any;
    logic                           xfer;
    logic                           burst_end;

    assign busy         = (state == ST_BURST);
    assign req_data_a   = req_data;
    assign fifo_wr_data = req_data_a[grant_id];

    // Reset is masked in so a burst caught by reset cannot write during the
    // reset cycle itself; ready is masked the same way so requesters never
    // see a handshake that the FIFO did not.
    assign xfer       = busy & req_valid[grant_id] & fifo_wr_vld & ~wr_rst;
    assign fifo_wr_en = xfer;

    always_comb begin
        req_ready = '0;
        if (busy && fifo_wr_vld && !wr_rst) req_ready[grant_id] = 1'b1;
    end

    // Burst ends on the packet's last beat or on the beat that reaches the
    // cap; beat_cnt still holds the count before this beat.
    assign burst_end = xfer &
                       (req_last[grant_id] | (beat_cnt == CNT_W'(MAX_BURST - 1)));

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Requests raised during a burst are only seen here.
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // Stalls and request gaps simply hold everything.
                    if (xfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (burst_end) begin
                            state  <= ST_IDLE;
                            rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0
                                                                     : grant_id + ID_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_wr_arbiter.sv
module tb_uart_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            wr_clk = 1'b0;
    logic            wr_rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   fifo_wr_data;
    logic            fifo_wr_en;
    logic            fifo_wr_vld;
    logic [1:0]      grant_id;
    logic            busy;

    uart_fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(16)) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_vld  (fifo_wr_vld),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] last;
        logic       wvld;
        logic [3:0] rdy;
        logic       en;
        logic       bsy;
        logic [1:0] gid;
    } vec_t;

    vec_t tbl [26];

    int n_chk  = 0;
    int n_fail = 0;

    // requester packet model: per-requester FIFO of {last, data}
    logic [8:0] mem [N][64];
    int head [N];
    int tail [N];
    int cur_owner;
    int n_wr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        wr_rst = 1'b1; req_valid = '0; req_last = '0; fifo_wr_vld = 1'b0;
        @(negedge wr_clk);
        @(negedge wr_clk);
        wr_rst = 1'b0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        cur_owner = -1;
        n_wr = 0;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    // One cycle of the requester model plus scoreboard checks.
    task automatic step(input int vprob, input int wprob);
        logic [N-1:0] hs;
        int who;
        @(negedge wr_clk);
        for (int i = 0; i < N; i++) begin
            if (head[i] < tail[i] && $urandom_range(99) < vprob) begin
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = mem[i][head[i]][7:0];
                req_last[i]          = mem[i][head[i]][8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        fifo_wr_vld = ($urandom_range(99) < wprob);
        #1;
        hs = req_valid & req_ready;
        chk("sb_single_handshake", ($countones(hs) <= 1), 1'b1);
        chk("sb_wr_en", fifo_wr_en, (hs != '0));
        if (hs != '0) begin
            who = 0;
            for (int i = 0; i < N; i++) if (hs[i]) who = i;
            chk("sb_wr_data", fifo_wr_data, mem[who][head[who]][7:0]);
            if (cur_owner >= 0) chk("sb_no_interleave", who, cur_owner);
            cur_owner = mem[who][head[who]][8] ? -1 : who;
            head[who]++;
            n_wr++;
        end
    endtask

    initial begin
        int runs [8];
        int nruns, cur_run, gap, total, k, plen;

        wr_rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_wr_vld = 1'b0;
        do_reset();

        //            rst   vld      last     w     rdy      en    bsy   gid
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[4]  = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[5]  = '{1'b0, 4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[6]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2};
        tbl[8]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2};
        tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2};
        tbl[11] = '{1'b0, 4'b1001, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2};
        tbl[12] = '{1'b0, 4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3};
        tbl[13] = '{1'b0, 4'b1001, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3};
        tbl[14] = '{1'b0, 4'b1001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[15] = '{1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[16] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1};
        tbl[17] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1};
        tbl[18] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[19] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1};
        tbl[20] = '{1'b0, 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1};
        tbl[21] = '{1'b0, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3};
        tbl[22] = '{1'b1, 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3};
        tbl[23] = '{1'b0, 4'b1001, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[24] = '{1'b0, 4'b1001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[25] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};

        req_data = 32'hD3D2D1D0;
        for (int v = 0; v < 26; v++) begin
            @(negedge wr_clk);
            wr_rst      = tbl[v].rst;
            req_valid   = tbl[v].vld;
            req_last    = tbl[v].last;
            fifo_wr_vld = tbl[v].wvld;
            #1;
            chk($sformatf("vec%0d_ready", v), req_ready, tbl[v].rdy);
            chk($sformatf("vec%0d_wr_en", v), fifo_wr_en, tbl[v].en);
            chk($sformatf("vec%0d_busy", v), busy, tbl[v].bsy);
            chk($sformatf("vec%0d_grant", v), grant_id, tbl[v].gid);
            chk($sformatf("vec%0d_data", v), fifo_wr_data, 8'hD0 + {6'd0, tbl[v].gid});
        end

        // 40-beat stream from requester 1 is cut into 16/16/8 with one
        // idle arbitration cycle between bursts.
        do_reset();
        for (int b = 0; b < 40; b++) push(1, {2'd1, 6'(b)}, (b == 39));
        nruns = 0; cur_run = 0; gap = 0;
        for (int c = 0; c < 120 && head[1] < tail[1]; c++) begin
            step(100, 100);
            if (fifo_wr_en) begin
                if (cur_run == 0 && nruns > 0) chk("stream_gap", gap, 1);
                cur_run++;
                gap = 0;
            end else begin
                if (cur_run > 0 && nruns < 8) begin runs[nruns] = cur_run; nruns++; end
                cur_run = 0;
                gap++;
            end
        end
        if (cur_run > 0 && nruns < 8) begin runs[nruns] = cur_run; nruns++; end
        chk("stream_drained", head[1], tail[1]);
        chk("stream_nbursts", nruns, 3);
        if (nruns == 3) begin
            chk("stream_burst0", runs[0], 16);
            chk("stream_burst1", runs[1], 16);
            chk("stream_burst2", runs[2], 8);
        end

        // Backpressure for 5 cycles after 2 beats: beat count must freeze so
        // the capped burst still carries exactly 16 beats.
        do_reset();
        for (int b = 0; b < 20; b++) push(2, {2'd2, 6'(b)}, (b == 19));
        for (int c = 0; c < 3; c++) step(100, 100);
        chk("stall_pre_beats", n_wr, 2);
        for (int c = 0; c < 5; c++) begin
            step(100, 0);
            chk("stall_wr_en", fifo_wr_en, 1'b0);
            chk("stall_ready", req_ready, 4'b0000);
            chk("stall_busy", busy, 1'b1);
        end
        for (int c = 0; c < 40; c++) begin
            step(100, 100);
            if (!fifo_wr_en) break;
        end
        chk("stall_burst_len", n_wr, 16);
        for (int c = 0; c < 40 && head[2] < tail[2]; c++) step(100, 100);
        chk("stall_total", n_wr, 20);

        // Random valid gaps and backpressure against the packet scoreboard.
        do_reset();
        total = 0;
        for (int r = 0; r < N; r++) begin
            k = 0;
            while (k < 30) begin
                plen = $urandom_range(1, 6);
                for (int b = 0; b < plen && k < 30; b++) begin
                    push(r, {2'(r), 6'(k)}, (b == plen - 1) || (k == 29));
                    k++;
                    total++;
                end
            end
        end
        for (int c = 0; c < 3000; c++) begin
            if (head[0] == tail[0] && head[1] == tail[1] &&
                head[2] == tail[2] && head[3] == tail[3]) break;
            step(70, 70);
        end
        for (int r = 0; r < N; r++) chk($sformatf("rand_drain%0d", r), head[r], tail[r]);
        chk("rand_total_writes", n_wr, total);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
